// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller states, completion codes and bus-drive owner select.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR_W,
    ST_REG,
    ST_WDATA,
    ST_RSTART,
    ST_ADDR_R,
    ST_RDATA,
    ST_STOP,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    SEL_IDLE  = 2'd0,
    SEL_START = 2'd1,
    SEL_BYTE  = 2'd2,
    SEL_STOP  = 2'd3
  } sel_t;

  localparam logic [1:0] I2C_ERR_OK      = 2'd0;
  localparam logic [1:0] I2C_ERR_ADDR    = 2'd1;
  localparam logic [1:0] I2C_ERR_DATA    = 2'd2;
  localparam logic [1:0] I2C_ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/i2c_drive_mux.sv
// Picks which bit-level generator drives SDA/SCL; both lines float high when nobody owns the bus.
// Purely combinational, no backpressure.
module i2c_drive_mux
  import i2c_pkg::*;
(
  input  sel_t sel,
  input  logic start_sda,
  input  logic start_scl,
  input  logic byte_sda,
  input  logic byte_scl,
  input  logic stop_sda,
  input  logic stop_scl,
  output logic sda,
  output logic scl
);

  always_comb begin
    sda = 1'b1;
    scl = 1'b1;
    case (sel)
      SEL_START: begin sda = start_sda; scl = start_scl; end
      SEL_BYTE:  begin sda = byte_sda;  scl = byte_scl;  end
      SEL_STOP:  begin sda = stop_sda;  scl = stop_scl;  end
      default:   ;
    endcase
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Register read/write I2C master sequencer: one command at a time, req/done to start/byte/stop blocks.
// Write bytes stall the byte engine until supplied; read bytes have no backpressure. I2C_SEQ_TIMEOUT_EN adds a watchdog.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ       = 25_000_000,
  parameter int I2C_FREQ       = 100_000,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 64 * CLK_FREQ / I2C_FREQ
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [6:0]       i_cmd_addr,
  input  logic             i_cmd_rd,
  input  logic [7:0]       i_cmd_reg,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic [7:0]       i_wdata,
  input  logic             i_wvalid,
  output logic             o_wready,
  output logic [7:0]       o_rdata,
  output logic             o_rvalid,
  output logic             o_done,
  output logic [1:0]       o_err,
  output logic             o_busy,
  output logic             o_start_req,
  input  logic             i_start_ready,
  input  logic             i_start_done,
  output logic             o_stop_req,
  input  logic             i_stop_ready,
  input  logic             i_stop_done,
  output logic             o_byte_req,
  input  logic             i_byte_ready,
  input  logic             i_byte_done,
  output logic             o_byte_rd,
  output logic             o_byte_mack,
  output logic [7:0]       o_byte_wdata,
  input  logic [7:0]       i_byte_rdata,
  input  logic             i_byte_nack,
  output logic [1:0]       o_sel,
  input  logic             i_start_sda,
  input  logic             i_start_scl,
  input  logic             i_byte_sda,
  input  logic             i_byte_scl,
  input  logic             i_stop_sda,
  input  logic             i_stop_scl,
  output logic             o_sda,
  output logic             o_scl
);

  state_t           state;
  sel_t             sel;
  logic             issued;
  logic [6:0]       addr_q;
  logic             rd_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       err_q;
  logic             cur_ready, cur_done, sub_op, waiting, issue, finish, timeout;

  always_comb begin
    cur_ready = 1'b0;
    cur_done  = 1'b0;
    sub_op    = 1'b1;
    case (state)
      ST_START, ST_RSTART: begin cur_ready = i_start_ready; cur_done = i_start_done; end
      ST_ADDR_W, ST_REG, ST_WDATA, ST_ADDR_R, ST_RDATA: begin
        cur_ready = i_byte_ready;
        cur_done  = i_byte_done;
      end
      ST_STOP: begin cur_ready = i_stop_ready; cur_done = i_stop_done; end
      default: sub_op = 1'b0;
    endcase
  end

  // A write byte is not issued until the stream has handed one over.
  assign waiting = sub_op && !(state == ST_WDATA && o_wready);
  assign issue   = waiting && !issued && cur_ready;
  assign finish  = waiting && issued && cur_done;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || !waiting || issue || finish) wd_cnt <= '0;
    else                                      wd_cnt <= wd_cnt + 1'b1;
  end
  assign timeout = waiting && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign o_busy      = (state != ST_IDLE);
  assign o_cmd_ready = (state == ST_IDLE);
  assign o_sel       = sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      sel          <= SEL_IDLE;
      issued       <= 1'b0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      reg_q        <= '0;
      cnt          <= '0;
      err_q        <= I2C_ERR_OK;
      o_err        <= I2C_ERR_OK;
      o_wready     <= 1'b0;
      o_rdata      <= '0;
      o_rvalid     <= 1'b0;
      o_done       <= 1'b0;
      o_start_req  <= 1'b0;
      o_stop_req   <= 1'b0;
      o_byte_req   <= 1'b0;
      o_byte_rd    <= 1'b0;
      o_byte_mack  <= 1'b0;
      o_byte_wdata <= '0;
    end else begin
      o_start_req <= 1'b0;
      o_stop_req  <= 1'b0;
      o_byte_req  <= 1'b0;
      o_rvalid    <= 1'b0;
      o_done      <= 1'b0;
      if (timeout) begin
        // Abandon the bus without a stop condition.
        state    <= ST_FIN;
        sel      <= SEL_IDLE;
        issued   <= 1'b0;
        o_wready <= 1'b0;
        o_done   <= 1'b1;
        o_err    <= I2C_ERR_TIMEOUT;
      end else begin
        if (issue) begin
          issued <= 1'b1;
          case (state)
            ST_START, ST_RSTART: begin o_start_req <= 1'b1; sel <= SEL_START; end
            ST_STOP:             begin o_stop_req  <= 1'b1; sel <= SEL_STOP;  end
            default:             begin o_byte_req  <= 1'b1; sel <= SEL_BYTE;  end
          endcase
          o_byte_rd   <= (state == ST_RDATA);
          o_byte_mack <= (state == ST_RDATA) && (cnt == LEN_W'(1));
          if (state == ST_ADDR_W) o_byte_wdata <= {addr_q, 1'b0};
          if (state == ST_REG)    o_byte_wdata <= reg_q;
          if (state == ST_ADDR_R) o_byte_wdata <= {addr_q, 1'b1};
        end
        case (state)
          ST_IDLE: if (i_cmd_valid) begin
            addr_q <= i_cmd_addr;
            rd_q   <= i_cmd_rd;
            reg_q  <= i_cmd_reg;
            cnt    <= i_cmd_len;
            err_q  <= I2C_ERR_OK;
            state  <= ST_START;
          end
          ST_WDATA: if (o_wready && i_wvalid) begin
            o_wready     <= 1'b0;
            o_byte_wdata <= i_wdata;
          end
          ST_FIN: begin
            state <= ST_IDLE;
            sel   <= SEL_IDLE;
          end
          default: ;
        endcase
        if (finish) begin
          issued <= 1'b0;
          case (state)
            ST_START:  state <= ST_ADDR_W;
            ST_RSTART: state <= ST_ADDR_R;
            ST_ADDR_W, ST_ADDR_R: begin
              if (i_byte_nack) begin err_q <= I2C_ERR_ADDR; state <= ST_STOP; end
              else state <= (state == ST_ADDR_W) ? ST_REG : ST_RDATA;
            end
            ST_REG: begin
              if (i_byte_nack) begin err_q <= I2C_ERR_DATA; state <= ST_STOP; end
              else if (cnt == '0) state <= ST_STOP;
              else if (rd_q) state <= ST_RSTART;
              else begin state <= ST_WDATA; o_wready <= 1'b1; end
            end
            ST_WDATA: begin
              cnt <= cnt - LEN_W'(1);
              if (i_byte_nack) begin err_q <= I2C_ERR_DATA; state <= ST_STOP; end
              else if (cnt == LEN_W'(1)) state <= ST_STOP;
              else o_wready <= 1'b1;
            end
            ST_RDATA: begin
              cnt      <= cnt - LEN_W'(1);
              o_rdata  <= i_byte_rdata;
              o_rvalid <= 1'b1;
              if (cnt == LEN_W'(1)) state <= ST_STOP;
            end
            ST_STOP: begin
              state  <= ST_FIN;
              o_done <= 1'b1;
              o_err  <= err_q;
            end
            default: ;
          endcase
        end
      end
    end
  end

  i2c_drive_mux u_mux (
    .sel       (sel),
    .start_sda (i_start_sda),
    .start_scl (i_start_scl),
    .byte_sda  (i_byte_sda),
    .byte_scl  (i_byte_scl),
    .stop_sda  (i_stop_sda),
    .stop_scl  (i_stop_scl),
    .sda       (o_sda),
    .scl       (o_scl)
  );

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: responder models for the bit-level blocks and a transaction-level bus model.
module tb_i2c_txn_sequencer;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic       i_rst = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [6:0] i_cmd_addr = '0;
  logic       i_cmd_rd = 1'b0;
  logic [7:0] i_cmd_reg = '0;
  logic [7:0] i_cmd_len = '0;
  logic [7:0] i_wdata = '0;
  logic       i_wvalid = 1'b0;
  logic       o_wready;
  logic [7:0] o_rdata;
  logic       o_rvalid, o_done, o_busy;
  logic [1:0] o_err;
  logic       o_start_req, o_stop_req, o_byte_req;
  logic       i_start_ready = 1'b1, i_start_done = 1'b0;
  logic       i_stop_ready = 1'b1, i_stop_done = 1'b0;
  logic       i_byte_ready = 1'b1, i_byte_done = 1'b0;
  logic       o_byte_rd, o_byte_mack;
  logic [7:0] o_byte_wdata;
  logic [7:0] i_byte_rdata = '0;
  logic       i_byte_nack = 1'b0;
  logic [1:0] o_sel;
  logic       i_start_sda = 1'b0, i_start_scl = 1'b0, i_byte_sda = 1'b0;
  logic       i_byte_scl = 1'b0, i_stop_sda = 1'b0, i_stop_scl = 1'b0;
  logic       o_sda, o_scl;

  i2c_txn_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_addr(i_cmd_addr),
    .i_cmd_rd(i_cmd_rd), .i_cmd_reg(i_cmd_reg), .i_cmd_len(i_cmd_len),
    .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
    .o_start_req(o_start_req), .i_start_ready(i_start_ready), .i_start_done(i_start_done),
    .o_stop_req(o_stop_req), .i_stop_ready(i_stop_ready), .i_stop_done(i_stop_done),
    .o_byte_req(o_byte_req), .i_byte_ready(i_byte_ready), .i_byte_done(i_byte_done),
    .o_byte_rd(o_byte_rd), .o_byte_mack(o_byte_mack), .o_byte_wdata(o_byte_wdata),
    .i_byte_rdata(i_byte_rdata), .i_byte_nack(i_byte_nack), .o_sel(o_sel),
    .i_start_sda(i_start_sda), .i_start_scl(i_start_scl), .i_byte_sda(i_byte_sda),
    .i_byte_scl(i_byte_scl), .i_stop_sda(i_stop_sda), .i_stop_scl(i_stop_scl),
    .o_sda(o_sda), .o_scl(o_scl)
  );

  int vectors = 0;
  int miscompares = 0;

  // Bus events: 0x0100 start, 0x02xx written byte, 0x030m read byte with master ack m, 0x0400 stop.
  logic [15:0] ev[$];
  logic [7:0]  rq[$], wq[$], rd_arr[$], pre_w[$], pre_r[$];
  int          bidx, ridx, nack_idx, hs_cnt;
  logic        taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge i_clk); #1;
      if (o_start_req) begin
        ev.push_back(16'h0100);
        check("start_sel", o_sel, 32'd1);
        check("start_drive", {o_sda, o_scl}, {i_start_sda, i_start_scl});
        i_start_ready = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
        i_start_done = 1'b1;
        @(posedge i_clk); #1;
        i_start_done = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
        i_start_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_clk); #1;
      if (o_stop_req) begin
        ev.push_back(16'h0400);
        check("stop_sel", o_sel, 32'd3);
        check("stop_drive", {o_sda, o_scl}, {i_stop_sda, i_stop_scl});
        i_stop_ready = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
        i_stop_done = 1'b1;
        @(posedge i_clk); #1;
        i_stop_done = 1'b0;
        check("done_after_stop", o_done, 32'd1);
        repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
        i_stop_ready = 1'b1;
      end
    end
  end

  initial begin
    int         idx;
    logic       rdb;
    logic [7:0] sent;
    forever begin
      @(posedge i_clk); #1;
      if (o_byte_req) begin
        idx = bidx;
        bidx++;
        rdb = o_byte_rd;
        ev.push_back(rdb ? {8'h03, 7'd0, o_byte_mack} : {8'h02, o_byte_wdata});
        check("byte_sel", o_sel, 32'd2);
        check("byte_drive", {o_sda, o_scl}, {i_byte_sda, i_byte_scl});
        i_byte_ready = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
        sent = (rdb && ridx < rd_arr.size()) ? rd_arr[ridx] : 8'($urandom);
        if (rdb) ridx++;
        i_byte_rdata = sent;
        i_byte_nack  = (idx == nack_idx);
        i_byte_done  = 1'b1;
        @(posedge i_clk); #1;
        i_byte_done = 1'b0;
        i_byte_nack = 1'b0;
        if (rdb) check("rvalid_after_done", {o_rvalid, o_rdata}, {1'b1, sent});
        repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
        i_byte_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_clk); #1;
      if (o_rvalid) rq.push_back(o_rdata);
    end
  end

  // Write-byte source with random valid gaps.
  initial begin
    forever begin
      @(negedge i_clk);
      taken = i_wvalid && o_wready;
      if (taken) hs_cnt++;
      @(posedge i_clk); #2;
      if (taken && wq.size() > 0) void'(wq.pop_front());
      i_wvalid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
      i_wdata  = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  task automatic run_txn(input logic [6:0] a, input logic rd, input logic [7:0] r,
                         input int len, input int nk);
    logic [15:0] xev[$];
    logic [7:0]  xrd[$];
    logic [7:0]  wl[$];
    int          xhs, t;
    logic [1:0]  xerr;
    xhs = 0;
    xerr = 2'd0;
    ev.delete(); rq.delete(); wq.delete(); rd_arr.delete();
    bidx = 0; ridx = 0; nack_idx = nk; hs_cnt = 0;
    for (int i = 0; i < len; i++) begin
      wl.push_back(i < pre_w.size() ? pre_w[i] : 8'($urandom));
      rd_arr.push_back(i < pre_r.size() ? pre_r[i] : 8'($urandom));
    end
    if (!rd) foreach (wl[i]) wq.push_back(wl[i]);
    pre_w.delete(); pre_r.delete();
    {i_start_sda, i_start_scl, i_byte_sda, i_byte_scl, i_stop_sda, i_stop_scl} = 6'($urandom);

    // Expected transaction on the bus.
    xev.push_back(16'h0100);
    xev.push_back({8'h02, a, 1'b0});
    if (nk == 0) xerr = 2'd1;
    else begin
      xev.push_back({8'h02, r});
      if (nk == 1) xerr = 2'd2;
      else if (rd && len > 0) begin
        xev.push_back(16'h0100);
        xev.push_back({8'h02, a, 1'b1});
        if (nk == 2) xerr = 2'd1;
        else for (int i = 0; i < len; i++) begin
          xev.push_back({8'h03, 7'd0, 1'(i == len - 1)});
          xrd.push_back(rd_arr[i]);
        end
      end else begin
        for (int i = 0; i < len; i++) begin
          xev.push_back({8'h02, wl[i]});
          xhs++;
          if (nk == 2 + i) begin xerr = 2'd2; break; end
        end
      end
    end
    xev.push_back(16'h0400);

    t = 0;
    while (!o_cmd_ready && t < 200) begin @(posedge i_clk); #1; t++; end
    i_cmd_valid = 1'b1;
    i_cmd_addr = a; i_cmd_rd = rd; i_cmd_reg = r; i_cmd_len = 8'(len);
    @(posedge i_clk); #1;
    check("accept", {o_busy, o_cmd_ready}, 32'b10);
    // Keep a conflicting command pending while busy; it must not be taken.
    i_cmd_addr = ~a; i_cmd_rd = ~rd; i_cmd_reg = ~r;
    t = 0;
    while (!o_done && t < 2000) begin @(posedge i_clk); #1; t++; end
    i_cmd_valid = 1'b0;
    check("done_seen", o_done, 32'd1);
    check("err", o_err, xerr);
    @(posedge i_clk); #1;
    check("idle_after", {o_busy, o_cmd_ready, o_sel, o_done}, 32'b01000);
    repeat (2) begin @(posedge i_clk); #1; end
    check("event_count", ev.size(), xev.size());
    for (int i = 0; i < xev.size() && i < ev.size(); i++) check("bus_event", ev[i], xev[i]);
    check("rvalid_count", rq.size(), xrd.size());
    for (int i = 0; i < xrd.size() && i < rq.size(); i++) check("rdata", rq[i], xrd[i]);
    check("wready_handshakes", hs_cnt, xhs);
  endtask

  initial begin
    int   t, len_r, nk_r;
    logic rd_r;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_status", {o_cmd_ready, o_busy, o_sel, o_done, o_rvalid, o_wready, o_err}, 32'h100);
    check("rst_reqs", {o_start_req, o_stop_req, o_byte_req}, 32'd0);
    check("rst_data", {o_rdata, o_byte_wdata}, 32'd0);
    check("rst_bus_released", {o_sda, o_scl}, 32'b11);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    pre_w = '{8'h0A, 8'h0B};
    run_txn(7'h33, 1'b0, 8'h80, 2, -1);
    pre_r = '{8'h11, 8'h22, 8'h33};
    run_txn(7'h33, 1'b1, 8'h00, 3, -1);
    run_txn(7'h33, 1'b0, 8'h10, 2, 0);
    run_txn(7'h2A, 1'b0, 8'h05, 4, 3);
    run_txn(7'h51, 1'b1, 8'h44, 2, 1);
    run_txn(7'h51, 1'b1, 8'h44, 2, 2);
    run_txn(7'h12, 1'b1, 8'h9C, 0, -1);
    run_txn(7'h7F, 1'b0, 8'hFF, 0, -1);

    // Reset in the middle of a read data phase.
    ev.delete(); rq.delete(); rd_arr.delete();
    bidx = 0; ridx = 0; nack_idx = -1;
    for (int i = 0; i < 3; i++) rd_arr.push_back(8'($urandom));
    t = 0;
    while (!o_cmd_ready && t < 200) begin @(posedge i_clk); #1; t++; end
    i_cmd_valid = 1'b1; i_cmd_addr = 7'h33; i_cmd_rd = 1'b1; i_cmd_reg = 8'h00; i_cmd_len = 8'd3;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    t = 0;
    while (rq.size() == 0 && t < 500) begin @(posedge i_clk); #1; t++; end
    check("rdata_before_reset", rq.size(), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("mid_reset_idle", {o_busy, o_cmd_ready, o_sel, o_done}, 32'b01000);
    check("mid_reset_reqs", {o_start_req, o_stop_req, o_byte_req}, 32'd0);
    repeat (10) begin @(posedge i_clk); #1; end
    check("no_stop_on_reset", ev[ev.size() - 1], 32'h0300);
    run_txn(7'h33, 1'b1, 8'h00, 3, -1);

    for (int k = 0; k < 40; k++) begin
      len_r = $urandom_range(0, 4);
      rd_r  = 1'($urandom);
      nk_r  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len_r + 3) : -1;
      run_txn(7'($urandom), rd_r, 8'($urandom), len_r, nk_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sequencer.md
# i2c_txn_sequencer

Register-level I2C master controller that sequences the start generator, byte engine and stop generator into complete register write and register read transactions. It accepts one command at a time and issues req/done handshakes to each bit-level sub-block. It selects which sub-block owns the SDA/SCL drive lines, streams write bytes in and read bytes out, and reports completion with an error code. It sits between the sensor-configuration/readout logic and the I2C bit-level generators.

## Interface
- CLK_FREQ, 25_000_000, system clock in Hz
- I2C_FREQ, 100_000, SCL rate in Hz (only used to derive the default timeout)
- LEN_W, 8, width of the byte-count field
- TIMEOUT_CYCLES, 64*CLK_FREQ/I2C_FREQ, per-sub-operation watchdog limit
- i_clk  in  1  system clock; one clock domain
- i_rst  in  1  reset, synchronous, active-high
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake; transfer on the cycle both are high
- i_cmd_addr  in  7  7-bit slave address
- i_cmd_rd  in  1  1 = register read, 0 = register write
- i_cmd_reg  in  8  register pointer byte
- i_cmd_len  in  LEN_W  data byte count
- i_wdata / i_wvalid / o_wready  in/in/out  8/1/1  write byte stream; byte taken when wvalid&wready
- o_rdata / o_rvalid  out  8/1  read byte, rvalid is a one-cycle pulse; no backpressure
- o_done  out  1  one-cycle completion pulse
- o_err  out  2  status valid with o_done: 0 ok, 1 address NACK, 2 data NACK, 3 timeout
- o_busy  out  1  high whenever state != IDLE
- o_start_req / i_start_ready / i_start_done  out/in/in  1  start (and repeated-start) generator handshake
- o_stop_req / i_stop_ready / i_stop_done  out/in/in  1  stop generator handshake
- o_byte_req / i_byte_ready / i_byte_done  out/in/in  1  byte engine handshake
- o_byte_rd, o_byte_mack  out  1  byte direction, and the master ACK bit for reads (0 = ACK, 1 = NACK)
- o_byte_wdata / i_byte_rdata  out/in  8  byte engine data
- i_byte_nack  in  1  slave NACK, valid with i_byte_done
- o_sel  out  2  drive owner: 0 idle (released high), 1 start, 2 byte, 3 stop

## Operation
- States: IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, STOP, FIN.
- Command latch: addr, rd, reg and len are latched at command acceptance. Write path: START→ADDR_W→REG→WDATA×len→STOP→FIN.
- Read path: START→ADDR_W→REG→RSTART→ADDR_R→RDATA×len→STOP→FIN. A read with len=0 follows the write path with no data bytes.
- Address bytes: ADDR_W sends {addr,0}; ADDR_R sends {addr,1}.
- Sub-operation rule: in each state the controller asserts the matching req for exactly one cycle, on the first cycle where the sub-block's ready is high. It then waits for that sub-block's done. o_sel is switched to the owner on the cycle req is asserted and held until the next owner's req.
- WDATA: o_wready is high until a byte is taken, then the byte is issued. If i_wvalid stays low, the sequencer waits with SCL held low by the byte engine.
- RDATA: o_byte_mack is 0 for every byte except the last, which gets 1. On each i_byte_done, o_rdata is presented and o_rvalid pulses.
- NACK: i_byte_nack on an address byte sets err=1; on REG or WDATA it sets err=2. In both cases the sequence jumps to STOP and the remaining bytes are skipped.
- FIN: o_done pulses for one cycle with o_err, then the block returns to IDLE and o_sel returns to 0.
- Counters: a byte counter loads len and decrements on each data byte. len=0 skips the WDATA/RDATA phase entirely.

## Timing
- Reset values: o_cmd_ready=1 from the first cycle after reset; o_wready, o_rvalid, o_done, all req outputs, o_busy and o_sel = 0; o_err=0; o_rdata and o_byte_wdata = 0.
- Reset asserted mid-transaction returns the block to IDLE next cycle with no stop issued.
- Acceptance: the command is accepted on cycle N. START req is asserted no earlier than N+1.
- After any sub-block done, the next req is issued no earlier than the following cycle.
- o_rvalid is asserted the cycle after i_byte_done.
- o_done is asserted the cycle after i_stop_done.
- Simultaneous done and NACK: NACK wins.
- i_cmd_valid while busy: ignored; o_cmd_ready is low.

## Configuration
- I2C_SEQ_TIMEOUT_EN defined: a watchdog counter reloads on each req and counts while waiting for ready or done. If it reaches TIMEOUT_CYCLES, the sequencer goes directly to FIN with err=3 and o_sel=0, releasing the bus without a stop.
- Undefined: no watchdog is built, the sequencer waits indefinitely, and err=3 is never produced.

## Structure
- Shared i2c_pkg holds the state enum, the err code constants (I2C_ERR_OK/ADDR/DATA/TIMEOUT) and the o_sel owner enum. Other I2C blocks reuse these.
- One sub-module, i2c_drive_mux: combinational selection of sda/scl drive from the three generators by o_sel, releasing both lines high when o_sel=0.

## Test plan
- Write addr 0x33, reg 0x80, len 2, data 0x0A,0x0B, slave always ACKs → bytes on bus 0x66,0x80,0x0A,0x0B; stop; o_done with err=0; two wready handshakes.
- Read addr 0x33, reg 0x00, len 3, slave returns 0x11,0x22,0x33 → 0x66,0x00, repeated start, 0x67; three rvalid pulses 0x11,0x22,0x33; mack 0,0,1; err=0.
- Write where ADDR_W gets NACK → no REG byte issued; stop issued; err=1.
- Write len 4 with NACK on the second data byte → stop follows; remaining bytes not requested; err=2.
- With I2C_SEQ_TIMEOUT_EN defined and i_byte_done never returned, TIMEOUT_CYCLES=100 → o_done with err=3 about 100 cycles after byte req; o_sel=0.
- Reset pulsed during RDATA → next cycle o_busy=0, o_cmd_ready=1, o_sel=0; a new command then completes normally.
